// File: rtl/riscv_cpu_imem_ahb_slave.sv
// riscv_cpu_imem_ahb_slave
//   AHB-Lite responder fronting the on-chip instruction/data SRAM. One master
//   per instance (no HSEL). Decodes the address phase, returns the addressed
//   word or commits byte-lane writes in the data phase, inserts WAIT_STATES
//   wait cycles per accepted legal transfer, and flags out-of-range or
//   misaligned accesses with the two-cycle ERROR response.
//
// Ports
//   cpu_clk, cpu_resetn       clock (rising edge), async active-low reset
//   s_ahb_haddr/hsize/htrans/hwrite   address-phase control
//   s_ahb_hwdata/hwstrb       data-phase write data and byte-lane enables
//   s_ahb_hrdata              read data (holds last read outside read phases)
//   s_ahb_hreadyout           1 = data phase completes / address accepted
//   s_ahb_hresp               0 = OKAY, 1 = ERROR

// Byte-lane merge: selects the incoming write byte when its strobe is set.
module riscv_cpu_imem_ahb_slave_lane (
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    input  logic       en,
    output logic [7:0] merged
);
    assign merged = en ? new_byte : old_byte;
endmodule

module riscv_cpu_imem_ahb_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        cpu_clk,
    input  logic        cpu_resetn,
    input  logic [31:0] s_ahb_haddr,
    input  logic [2:0]  s_ahb_hsize,
    input  logic [1:0]  s_ahb_htrans,
    input  logic        s_ahb_hwrite,
    input  logic [31:0] s_ahb_hwdata,
    input  logic [3:0]  s_ahb_hwstrb,
    output logic [31:0] s_ahb_hrdata,
    output logic        s_ahb_hreadyout,
    output logic        s_ahb_hresp
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] a_idx;
    logic          legal;
    logic          accept;
    logic          commit;
    logic [31:0]   cur_word;
    logic [3:0][7:0] merged;

    // BUSY vs IDLE is indistinguishable to a single-beat responder.
    logic unused_htrans0;
    assign unused_htrans0 = s_ahb_htrans[0];

    // Offset from BASE_ADDR; wraparound below the base lands far out of range.
    assign off   = s_ahb_haddr - BASE_ADDR;
    assign a_idx = off[AW+1:2];
    assign legal = (off < 32'(4 * DEPTH_WORDS)) && (s_ahb_hsize <= 3'd2)
                && !((s_ahb_hsize == 3'd1) && off[0])
                && !((s_ahb_hsize == 3'd2) && (off[1:0] != 2'b00));

    assign accept = s_ahb_hreadyout && s_ahb_htrans[1];
    assign commit = (state_q == S_DATA) && wr_q;

    assign cur_word = mem[idx_q];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        riscv_cpu_imem_ahb_slave_lane u_lane (
            .old_byte (cur_word[8*i +: 8]),
            .new_byte (s_ahb_hwdata[8*i +: 8]),
            .en       (s_ahb_hwstrb[i]),
            .merged   (merged[i])
        );
    end

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM array is never reset; only the DATA cycle of a legal write commits.
    always_ff @(posedge cpu_clk) begin
        if (commit) mem[idx_q] <= merged;
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd0;
                    if (!wr_q) rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all accept a new address phase.
                if (accept) begin
                    if (legal) begin
                        idx_d = a_idx;
                        wr_d  = s_ahb_hwrite;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end else begin
                            state_d = S_DATA;
                            // A write to the same word commits on this edge;
                            // forward its merged lanes so the read sees them.
                            if (!s_ahb_hwrite)
                                rdata_d = (commit && (a_idx == idx_q)) ? merged : mem[a_idx];
                        end
                    end else begin
                        state_d = S_ERR1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        s_ahb_hreadyout = 1'b1;
        s_ahb_hresp     = 1'b0;
        case (state_q)
            S_WAIT: s_ahb_hreadyout = 1'b0;
            S_ERR1: begin
                s_ahb_hreadyout = 1'b0;
                s_ahb_hresp     = 1'b1;
            end
            S_ERR2: s_ahb_hresp = 1'b1;
            default: ;
        endcase
    end

    assign s_ahb_hrdata = rdata_q;

endmodule

// File: doc/riscv_cpu_imem_ahb_slave.md
# riscv_cpu_imem_ahb_slave

AHB-Lite responder (subordinate) implementing the on-chip instruction/data SRAM that the CPU fetch unit and load/store unit master. Decodes address-phase signals, returns read data or commits byte-lane writes in the data phase, and inserts a programmable number of wait states. Signals out-of-range or misaligned accesses with the two-cycle AHB ERROR response. Point-to-point: one master per instance, no HSEL.

## Interface
- BASE_ADDR, 32'h00000000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536
- WAIT_STATES, 0, data-phase wait cycles per accepted transfer, 0..15
- cpu_clk  input  1  clock; all state on rising edge
- cpu_resetn  input  1  reset, asynchronous, active-low
- s_ahb_haddr  input  32  address-phase byte address
- s_ahb_hsize  input  3  0=byte, 1=half, 2=word; >2 illegal
- s_ahb_htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- s_ahb_hwrite  input  1  address phase: 1=write
- s_ahb_hwdata  input  32  data-phase write data
- s_ahb_hwstrb  input  4  data-phase byte-lane enables
- s_ahb_hrdata  output  32  read data, valid in completing data-phase cycle
- s_ahb_hreadyout  output  1  1=data phase completes / address accepted this cycle
- s_ahb_hresp  output  1  0=OKAY, 1=ERROR

## Operation
- Transfer accepted on rising edge where hreadyout=1 and htrans[1]=1. IDLE/BUSY: no transfer, next cycle OKAY, hreadyout=1.
- Legal iff (haddr-BASE_ADDR) < 4*DEPTH_WORDS, hsize<=2, half: haddr[0]=0, word: haddr[1:0]=00. Word index = (haddr-BASE_ADDR)>>2.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. Legal accept -> WAIT (WAIT_STATES>0, counter=WAIT_STATES) or DATA; illegal accept -> ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements; at 1 -> DATA.
  - DATA: hreadyout=1, hresp=0; completes transfer. Same cycle may accept next transfer (pipelined), transitions as from IDLE; no accept -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2. ERR2: hreadyout=1, hresp=1; accepts next transfer as from IDLE.
- Reads: full addressed word on hrdata regardless of hsize; master extracts lanes. hrdata holds last read value outside read data phases.
- Writes: on DATA-state edge, lanes with hwstrb[i]=1 written from hwdata[8i+7:8i]; hwstrb=0000 writes nothing. Illegal writes never modify memory.
- Read-after-write: read accepted in the DATA cycle of a write to same word returns post-write data (per-lane bypass).
- hwdata/hwstrb ignored outside DATA state of a write.

## Timing
- Reset (async assert): state=IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0; in-flight transfer dropped, no write committed. Memory contents not reset.
- Zero-wait latency: accept edge N, data phase cycle N+1, hrdata valid and hreadyout=1 during N+1.
- Wait latency: hreadyout=0 for exactly WAIT_STATES cycles after accept, then one DATA cycle.
- Back-to-back SEQ/NONSEQ with WAIT_STATES=0: one transfer per cycle sustained.
- ERROR: exactly two cycles, hresp=1 both, hreadyout 0 then 1.
- Address/control sampled only on accepting edges; changes while hreadyout=0 are ignored.

## Test plan
- Reset then word read at BASE_ADDR+8 (preloaded 32'h00000013), WAIT_STATES=0 -> next cycle hrdata=32'h00000013, hreadyout=1, hresp=0.
- Byte write haddr=BASE+5, hwstrb=0010, hwdata=32'h0000AB00 onto word 32'h11223344, then immediate read of BASE+4 -> 32'h1122AB44 (bypass path).
- WAIT_STATES=3, 4 sequential word reads -> each data phase shows hreadyout 0,0,0,1; correct words in order; address held during waits not resampled.
- Read haddr=BASE+4*DEPTH_WORDS, and word read haddr=BASE+2 -> each: hresp=1/hreadyout=0, then hresp=1/hreadyout=1; memory unchanged; next legal read OKAY.
- Interleaved IDLE/BUSY/NONSEQ stream, WAIT_STATES=0 -> IDLE/BUSY produce OKAY zero-wait with no memory access; hrdata holds previous value.
- Assert cpu_resetn=0 during WAIT of a write -> outputs immediately hreadyout=1, hresp=0, hrdata=0; target word unchanged after release.
